cmd_extractor: RTL and testbench

CMD_EXTRACTOR -- requirements
Module: cmd_extractor

---
 rtl/cmd_extractor.sv | 206 ++++++++++++++++++++
 tb/tb_cmd_extractor.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_extractor.sv
// UART 8N1 transmitter plus a receiver feeding a small command parser
// (GET/DEL: opcode,key; SET: opcode,key,value[23:0] MSB first).
module cmd_extractor #(
    parameter logic [7:0] OP_GET = 8'd1,
    parameter logic [7:0] OP_DEL = 8'd2,
    parameter logic [7:0] OP_SET = 8'd3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ticker,
    input  logic [7:0]  tx_data,
    input  logic        tx_load_n,
    output logic        tx_serial,
    output logic        tx_busy,
    input  logic        rx_serial,
    output logic        cmd_valid,
    output logic [7:0]  cmd_op,
    output logic [7:0]  cmd_key,
    output logic [23:0] cmd_value,
    output logic        cmd_err
);
    localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;
    localparam logic [1:0] RX_IDLE = 2'd0, RX_DATA = 2'd1, RX_STOP = 2'd2;
    localparam logic [2:0] PS_OPC = 3'd0, PS_KEY = 3'd1, PS_V2 = 3'd2, PS_V1 = 3'd3, PS_V0 = 3'd4;

    logic [1:0] r_tick_s, r_load_s, r_rx_s, r_arm;
    logic       r_tick_d, r_load_d;
    logic       w_tick_rise, w_tick_fall, w_load_fall, w_rx;

    // r_load_d only records synchronized highs once the reset value has
    // flushed out of the chain, so a tx_load_n held low across reset
    // never looks like a fresh falling edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tick_s <= 2'b00;
            r_load_s <= 2'b11;
            r_rx_s   <= 2'b11;
            r_arm    <= 2'b00;
            r_tick_d <= 1'b0;
            r_load_d <= 1'b0;
        end else begin
            r_tick_s <= {r_tick_s[0], ticker};
            r_load_s <= {r_load_s[0], tx_load_n};
            r_rx_s   <= {r_rx_s[0], rx_serial};
            r_arm    <= {r_arm[0], 1'b1};
            r_tick_d <= r_tick_s[1];
            r_load_d <= r_load_s[1] & r_arm[1];
        end
    end

    assign w_tick_rise = r_tick_s[1] & ~r_tick_d;
    assign w_tick_fall = ~r_tick_s[1] & r_tick_d;
    assign w_load_fall = r_load_d & ~r_load_s[1];
    assign w_rx        = r_rx_s[1];

    logic [1:0] r_tx_st;
    logic [7:0] r_tx_sh;
    logic [3:0] r_tx_cnt;
    logic       r_tx_ser, r_tx_busy;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_st   <= TX_IDLE;
            r_tx_sh   <= 8'd0;
            r_tx_cnt  <= 4'd0;
            r_tx_ser  <= 1'b1;
            r_tx_busy <= 1'b0;
        end else begin
            case (r_tx_st)
                TX_IDLE: if (w_load_fall) begin
                    r_tx_sh   <= tx_data;
                    r_tx_cnt  <= 4'd0;
                    r_tx_busy <= 1'b1;
                    r_tx_st   <= TX_START;
                end
                TX_START: if (w_tick_rise) begin
                    r_tx_ser <= 1'b0;
                    r_tx_st  <= TX_DATA;
                end
                TX_DATA: if (w_tick_rise) begin
                    if (r_tx_cnt == 4'd8) begin
                        r_tx_ser <= 1'b1;
                        r_tx_st  <= TX_STOP;
                    end else begin
                        r_tx_ser <= r_tx_sh[r_tx_cnt[2:0]];
                        r_tx_cnt <= r_tx_cnt + 4'd1;
                    end
                end
                default: if (w_tick_rise) begin
                    r_tx_busy <= 1'b0;
                    r_tx_st   <= TX_IDLE;
                end
            endcase
        end
    end

    assign tx_serial = r_tx_ser;
    assign tx_busy   = r_tx_busy;

    logic [1:0] r_rx_st;
    logic [7:0] r_rx_sh;
    logic [2:0] r_rx_cnt;
    logic       r_byte_vld, r_frm_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_st    <= RX_IDLE;
            r_rx_sh    <= 8'd0;
            r_rx_cnt   <= 3'd0;
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_byte_vld <= 1'b0;
            r_frm_err  <= 1'b0;
            if (w_tick_fall) begin
                case (r_rx_st)
                    RX_IDLE: if (!w_rx) begin
                        r_rx_cnt <= 3'd0;
                        r_rx_st  <= RX_DATA;
                    end
                    RX_DATA: begin
                        r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
                        r_rx_cnt <= r_rx_cnt + 3'd1;
                        if (r_rx_cnt == 3'd7) r_rx_st <= RX_STOP;
                    end
                    default: begin
                        r_byte_vld <= w_rx;
                        r_frm_err  <= ~w_rx;
                        r_rx_st    <= RX_IDLE;
                    end
                endcase
            end
        end
    end

    logic [2:0]  r_ps;
    logic [7:0]  r_p_op, r_p_key, r_cmd_op, r_cmd_key;
    logic [23:0] r_p_val, r_cmd_value;
    logic        r_cmd_valid, r_cmd_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ps        <= PS_OPC;
            r_p_op      <= 8'd0;
            r_p_key     <= 8'd0;
            r_p_val     <= 24'd0;
            r_cmd_op    <= 8'd0;
            r_cmd_key   <= 8'd0;
            r_cmd_value <= 24'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            if (r_frm_err) begin
                r_cmd_err <= 1'b1;
                r_ps      <= PS_OPC;
            end else if (r_byte_vld) begin
                case (r_ps)
                    PS_OPC: begin
                        if (r_rx_sh == OP_GET || r_rx_sh == OP_DEL || r_rx_sh == OP_SET) begin
                            r_p_op <= r_rx_sh;
                            r_ps   <= PS_KEY;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                    PS_KEY: begin
                        r_p_key <= r_rx_sh;
                        if (r_p_op == OP_SET) begin
                            r_ps <= PS_V2;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_op    <= r_p_op;
                            r_cmd_key   <= r_rx_sh;
                            r_cmd_value <= 24'd0;
                            r_ps        <= PS_OPC;
                        end
                    end
                    PS_V2: begin
                        r_p_val[23:16] <= r_rx_sh;
                        r_ps           <= PS_V1;
                    end
                    PS_V1: begin
                        r_p_val[15:8] <= r_rx_sh;
                        r_ps          <= PS_V0;
                    end
                    PS_V0: begin
                        r_cmd_valid <= 1'b1;
                        r_cmd_op    <= r_p_op;
                        r_cmd_key   <= r_p_key;
                        r_cmd_value <= {r_p_val[23:8], r_rx_sh};
                        r_ps        <= PS_OPC;
                    end
                    default: r_ps <= PS_OPC;
                endcase
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_err   = r_cmd_err;
    assign cmd_op    = r_cmd_op;
    assign cmd_key   = r_cmd_key;
    assign cmd_value = r_cmd_value;
endmodule

// File: tb/tb_cmd_extractor.sv
// Bench for cmd_extractor: byte-stream command model with an event queue,
// directed loopback/framing/reset cases and randomized receive traffic.
module tb_cmd_extractor;
    logic        clock = 0, reset_n = 1, ticker = 0, tx_load_n = 1;
    logic        rx_drv = 1, loop_en = 1;
    logic [7:0]  tx_data = 0;
    logic        tx_serial, tx_busy, rx_serial, cmd_valid, cmd_err;
    logic [7:0]  cmd_op, cmd_key;
    logic [23:0] cmd_value;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    cmd_extractor dut (
        .clock(clock), .reset_n(reset_n), .ticker(ticker), .tx_data(tx_data),
        .tx_load_n(tx_load_n), .tx_serial(tx_serial), .tx_busy(tx_busy),
        .rx_serial(rx_serial), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_key(cmd_key), .cmd_value(cmd_value), .cmd_err(cmd_err)
    );

    always #5 clock = ~clock;
    always #83 ticker = ~ticker;   // bit time 166, not a multiple of the clock

    int vectors = 0, errors = 0, n_valid = 0, n_err = 0;

    typedef struct {
        bit          is_err;
        logic [7:0]  op, key;
        logic [23:0] val;
    } ev_t;
    ev_t         exp_q[$];
    logic [7:0]  m_buf[5];
    int          m_len = 0;
    logic [7:0]  m_op = 0, m_key = 0;
    logic [23:0] m_val = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command model: collect bytes until a command is complete or invalid.
    task automatic model_byte(input logic [7:0] b, input bit ok);
        ev_t e;
        e.is_err = 1; e.op = 0; e.key = 0; e.val = 0;
        if (!ok) begin
            exp_q.push_back(e);
            m_len = 0;
            return;
        end
        m_buf[m_len] = b;
        m_len++;
        if (m_len == 1 && !(b inside {8'd1, 8'd2, 8'd3})) begin
            exp_q.push_back(e);
            m_len = 0;
        end else if ((m_len == 2 && m_buf[0] != 8'd3) || m_len == 5) begin
            e.is_err = 0;
            e.op  = m_buf[0];
            e.key = m_buf[1];
            e.val = (m_len == 5) ? {m_buf[2], m_buf[3], m_buf[4]} : 24'd0;
            exp_q.push_back(e);
            m_len = 0;
        end
    endtask

    always @(negedge clock) begin : cmp
        ev_t e;
        if (reset_n) begin
            if (cmd_valid) n_valid++;
            if (cmd_err) n_err++;
            if (cmd_valid || cmd_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, cmd_valid, cmd_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", {30'd0, cmd_valid, cmd_err}, e.is_err ? 32'd1 : 32'd2);
                    if (!e.is_err) begin
                        check("cmd_op", cmd_op, e.op);
                        check("cmd_key", cmd_key, e.key);
                        check("cmd_value", cmd_value, e.val);
                        m_op = e.op; m_key = e.key; m_val = e.val;
                    end
                end
            end else begin
                check("hold_op", cmd_op, m_op);
                check("hold_key", cmd_key, m_key);
                check("hold_value", cmd_value, m_val);
            end
        end
    end

    task automatic clear_model;
        exp_q.delete();
        m_len = 0; m_op = 0; m_key = 0; m_val = 0;
    endtask

    task automatic reset_dut;
        reset_n = 0;
        clear_model();
        loop_en = 1; rx_drv = 1; tx_load_n = 1;
        #1;
        check("rst_tx_serial", tx_serial, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_cmd_op", cmd_op, 0);
        check("rst_cmd_key", cmd_key, 0);
        check("rst_cmd_value", cmd_value, 0);
        repeat (3) @(posedge clock);
        #2 reset_n = 1;
        repeat (3) @(posedge clock);
    endtask

    task automatic load_byte(input logic [7:0] b);
        tx_data = b;
        @(posedge clock);
        tx_load_n = 0;
        repeat (4) @(posedge clock);
        tx_load_n = 1;
    endtask

    task automatic wait_busy_low;
        int k = 0;
        while (tx_busy && k < 400) begin @(posedge clock); k++; end
        check("tx_busy_fall", tx_busy, 0);
    endtask

    task automatic send_tx(input logic [7:0] b);
        int k = 0;
        loop_en = 1;
        model_byte(b, 1);
        load_byte(b);
        while (!tx_busy && k < 20) begin @(posedge clock); k++; end
        check("tx_busy_rise", tx_busy, 1);
        wait_busy_low();
        repeat (4) @(posedge clock);
        check("latency_drain", exp_q.size(), 0);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop);
        model_byte(b, stop);
        loop_en = 0;
        @(posedge ticker); rx_drv = 0;
        for (int i = 0; i < 8; i++) begin @(posedge ticker); rx_drv = b[i]; end
        @(posedge ticker); rx_drv = stop;
        @(posedge ticker); rx_drv = 1;
        repeat (4) @(posedge clock);
        check("latency_drain", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] exp_bits;
        logic [7:0] set_seq[5];
        real t0, t1;
        int k, v0, e0, rises;
        logic prev;
        logic [7:0] b;

        #1 reset_dut();

        // Single byte 0x03: exact line pattern and busy length.
        exp_bits = 10'b10_0000_0110;
        load_byte(8'h03);
        check("busy_after_load", tx_busy, 1);
        k = 0;
        while (tx_serial && k < 200) begin @(posedge clock); k++; end
        t0 = $realtime;
        for (int i = 0; i < 10; i++) begin
            @(negedge ticker); #1;
            check("tx_bit", tx_serial, exp_bits[i]);
        end
        k = 0;
        while (tx_busy && k < 200) begin @(posedge clock); k++; end
        t1 = $realtime;
        check("busy_10_bits", (t1 - t0 > 1635.0 && t1 - t0 < 1685.0) ? 1 : 0, 1);
        reset_dut();

        // SET 3,45,9,67,101 looped back.
        set_seq[0] = 8'd3; set_seq[1] = 8'd45; set_seq[2] = 8'd9;
        set_seq[3] = 8'd67; set_seq[4] = 8'd101;
        v0 = n_valid; e0 = n_err;
        for (int i = 0; i < 5; i++) send_tx(set_seq[i]);
        check("set_valid_cnt", n_valid - v0, 1);
        check("set_err_cnt", n_err - e0, 0);
        check("set_op", cmd_op, 8'd3);
        check("set_key", cmd_key, 8'd45);
        check("set_value", cmd_value, 24'h094365);

        // GET 1,200.
        send_tx(8'd1); send_tx(8'd200);
        check("get_op", cmd_op, 8'd1);
        check("get_key", cmd_key, 8'd200);
        check("get_value", cmd_value, 24'd0);

        // Bad opcode then SET.
        v0 = n_valid; e0 = n_err;
        send_tx(8'h7F);
        for (int i = 0; i < 5; i++) send_tx(set_seq[i]);
        check("badop_err_cnt", n_err - e0, 1);
        check("badop_valid_cnt", n_valid - v0, 1);
        check("badop_value", cmd_value, 24'h094365);

        // Framing error on the key byte.
        v0 = n_valid; e0 = n_err;
        send_rx(8'd1, 1); send_rx(8'd77, 0);
        check("frm_err_cnt", n_err - e0, 1);
        check("frm_valid_cnt", n_valid - v0, 0);
        send_rx(8'd2, 1); send_rx(8'd9, 1);
        check("frm_next_op", cmd_op, 8'd2);
        check("frm_next_key", cmd_key, 8'd9);

        // Transmit and receive at the same time.
        fork
            load_byte(8'hA5);
            begin send_rx(8'd2, 1); send_rx(8'h10, 1); end
        join
        wait_busy_low();
        check("simul_key", cmd_key, 8'h10);

        // Randomized receive traffic, biased toward valid opcodes.
        for (int n = 0; n < 40; n++) begin
            b = ($urandom_range(0, 9) < 5) ? 8'($urandom_range(1, 3)) : 8'($urandom);
            send_rx(b, $urandom_range(0, 9) != 0);
        end

        // tx_load_n held low for 80 bit times -> one frame.
        reset_dut();
        tx_data = 8'hF0;
        model_byte(8'hF0, 1);
        tx_load_n = 0;
        rises = 0; prev = tx_busy;
        repeat (1328) begin
            @(posedge clock);
            if (tx_busy && !prev) rises++;
            prev = tx_busy;
        end
        tx_load_n = 1;
        check("held_low_frames", rises, 1);
        repeat (4) @(posedge clock);
        check("held_low_drain", exp_q.size(), 0);

        // Reset mid-frame with tx_load_n still low.
        tx_data = 8'h01;
        tx_load_n = 0;
        k = 0;
        while (tx_serial && k < 200) begin @(posedge clock); k++; end
        check("mf_started", tx_serial, 0);
        repeat (40) @(posedge clock);
        reset_n = 0;
        clear_model();
        #1;
        check("mf_tx_serial", tx_serial, 1);
        check("mf_tx_busy", tx_busy, 0);
        check("mf_cmd_valid", cmd_valid, 0);
        repeat (3) @(posedge clock);
        reset_n = 1;
        rises = 0;
        repeat (600) begin @(posedge clock); if (tx_busy) rises++; end
        check("mf_no_retrigger", rises, 0);
        tx_load_n = 1;
        repeat (5) @(posedge clock);
        send_tx(8'd2); send_tx(8'd7);
        check("mf_after_op", cmd_op, 8'd2);
        check("mf_after_key", cmd_key, 8'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
